mdu_div: RTL and testbench

Multi-cycle radix-2 integer divider for the EX stage, responding to the ALU's DIV/DIVU requests over a start/annul/ready handshake. It accepts two 32-bit operands, signed or unsigned, and iterates one quotient bit per cycle. It returns a 64-bit `{remainder, quotient}` result, which the ALU forwards unchanged to HI/LO. While a division is in flight, the ALU holds `start_i` and stalls the pipeline until `ready_o` rises.

---
 rtl/mdu_div_pkg.sv | 14 +
 rtl/mdu_div.sv | 116 +++++++++++
 tb/tb_mdu_div.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mdu_div_pkg.sv
// Shared EX-stage definitions for the multi-cycle integer divider.
package mdu_div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DBZ  = 2'd1,
        ON   = 2'd2,
        END  = 2'd3
    } div_state_e;

endpackage

// File: rtl/mdu_div.sv
// Radix-2 restoring divider: one quotient bit per cycle, {remainder, quotient} result
// with a one-cycle ready pulse; annul aborts without touching the held result.
module mdu_div
    import mdu_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    div_state_e             state_q;
    logic [DIV_CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]       rem_q;
    logic [WIDTH-1:0]       quo_q;
    logic [WIDTH-1:0]       b_abs_q;
    logic                   q_neg_q;
    logic                   r_neg_q;
    logic [2*WIDTH-1:0]     result_q;
    logic                   ready_q;

    logic [WIDTH:0]         shrem;
    logic                   geq;
    logic [WIDTH-1:0]       diff;
    logic [WIDTH-1:0]       rem_step;
    logic [WIDTH-1:0]       quo_step;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? WIDTH'(~x + WIDTH'(1)) : x;
    endfunction

    // Magnitude of 0x80000000 is kept as the unsigned value 0x80000000.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic sgn);
        return neg_if(x, sgn & x[WIDTH-1]);
    endfunction

    // One restoring step; the quotient shifts out its MSB into the remainder.
    always_comb begin
        shrem    = {rem_q, quo_q[WIDTH-1]};
        geq      = (shrem >= {1'b0, b_abs_q});
        diff     = shrem[WIDTH-1:0] - b_abs_q;
        rem_step = geq ? diff : shrem[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], geq};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            b_abs_q  <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (start_i && !annul_i) begin
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= abs_val(a_i, signed_div_i);
                        b_abs_q <= abs_val(b_i, signed_div_i);
                        q_neg_q <= signed_div_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        r_neg_q <= signed_div_i & a_i[WIDTH-1];
                        state_q <= (b_i == '0) ? DBZ : ON;
                    end
                end
                DBZ: begin
                    if (annul_i) begin
                        state_q <= IDLE;
                    end else begin
                        result_q <= '0;
                        ready_q  <= 1'b1;
                        state_q  <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        cnt_q <= cnt_q + DIV_CNT_W'(1);
                        if (cnt_q == DIV_CNT_W'(WIDTH - 1)) begin
                            result_q <= {neg_if(rem_step, r_neg_q), neg_if(quo_step, q_neg_q)};
                            ready_q  <= 1'b1;
                            state_q  <= END;
                        end
                    end
                end
                END: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_mdu_div.sv
// Scoreboard bench for mdu_div: directed divisions, divide-by-zero, annul, async reset, back-to-back.
module tb_mdu_div;

    localparam int unsigned W = 32;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             signed_div_i;
    logic [W-1:0]     a_i;
    logic [W-1:0]     b_i;
    logic             start_i;
    logic             annul_i;
    logic [2*W-1:0]   result_o;
    logic             ready_o;

    typedef struct {
        logic [2*W-1:0] res;
        int             cyc;
        string          name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    mdu_div #(.WIDTH(W)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .signed_div_i (signed_div_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [2*W-1:0] got, input logic [2*W-1:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", n, got, req);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_n_i === 1'b1 && ready_o === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ready got result=%h required=no ready", result_o);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_result"}, result_o, e.res);
                    chk({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Issue one request, hold start until ready (ALU style), optionally scramble inputs meanwhile.
    task automatic do_div(input string n, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [2*W-1:0] res, input int lat,
                          input bit perturb, output int rdy_cyc);
        exp_t e;
        bit   got;
        @(negedge clk_i);
        a_i = a; b_i = b; signed_div_i = s; start_i = 1'b1;
        @(posedge clk_i); #1;
        e.res = res; e.cyc = cyc + lat; e.name = n;
        exp_q.push_back(e);
        got = 1'b0;
        rdy_cyc = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_i);
            if (ready_o === 1'b1) begin
                got = 1'b1;
                rdy_cyc = cyc;
                start_i = 1'b0;
            end else if (perturb) begin
                start_i      = ~start_i;
                a_i          = $urandom;
                b_i          = $urandom;
                signed_div_i = ~signed_div_i;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout got=no ready required=ready within 40 cycles", n);
            start_i = 1'b0;
        end
    endtask

    initial begin
        int r0, r1;
        rst_n_i = 1'b0; signed_div_i = 1'b0; a_i = '0; b_i = '0;
        start_i = 1'b0; annul_i = 1'b0;
        #12;
        chk("reset_result", result_o, 64'd0);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        @(negedge clk_i); rst_n_i = 1'b1;

        do_div("udiv_100_7",  32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 32, 1'b0, r0);
        do_div("sdiv_m7_2",   32'hFFFFFFF9,   32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD, 32, 1'b0, r0);
        do_div("sdiv_7_m2",   32'd7,          32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD, 32, 1'b0, r0);
        do_div("udiv_m7_2",   32'hFFFFFFF9,   32'd2,          1'b0, 64'h00000001_7FFFFFFC, 32, 1'b0, r0);
        do_div("dbz_5_0",     32'd5,          32'd0,          1'b0, 64'd0,                 1,  1'b0, r0);
        do_div("sdiv_minint", 32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000, 32, 1'b0, r0);

        // Annul mid-operation: no ready, result untouched.
        @(negedge clk_i);
        a_i = 32'd1000; b_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i); #1;
        repeat (10) @(posedge clk_i);
        #1; annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk_i); #1; annul_i = 1'b0;
        repeat (40) @(negedge clk_i);
        chk("annul_result_hold", result_o, 64'h00000000_80000000);
        do_div("after_annul_9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 32, 1'b0, r0);

        // Asynchronous reset in the middle of a division.
        @(negedge clk_i);
        a_i = 32'd12345; b_i = 32'd17; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i); #1;
        repeat (15) @(posedge clk_i);
        #2; rst_n_i = 1'b0;
        #1;
        chk("midop_reset_result", result_o, 64'd0);
        chk("midop_reset_ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        @(negedge clk_i); @(negedge clk_i); rst_n_i = 1'b1;
        do_div("after_reset_10_4", 32'd10, 32'd4, 1'b0, 64'h00000002_00000002, 32, 1'b0, r0);

        // Back-to-back, with input scrambling during the second operation.
        do_div("b2b_first",  32'hFFFFFFFF, 32'h10, 1'b0, 64'h0000000F_0FFFFFFF, 32, 1'b0, r0);
        do_div("b2b_second", 32'hFFFFFF9C, 32'd7,  1'b1, 64'hFFFFFFFE_FFFFFFF2, 32, 1'b1, r1);
        chk("b2b_gap", 64'(r1 - r0), 64'd34);
        do_div("udiv_max_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h00000000_00000001, 32, 1'b0, r0);

        repeat (5) @(negedge clk_i);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
